// File: rtl/debug_step_controller_pkg.sv
// debug_step_controller_pkg: shared state/command encodings and default widths
package debug_step_controller_pkg;
   localparam int NB_BITS_DEF = 32;
   localparam int NB_STEP_DEF = 16;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP, ST_HALTED} state_e;
   typedef enum logic [1:0] {CMD_RUN, CMD_STEP, CMD_STOP, CMD_CLEAR} cmd_e;
endpackage

// File: rtl/debug_step_controller.sv
// debug_step_controller: run/step/halt sequencer producing the pipeline advance enable
module debug_step_controller
   import debug_step_controller_pkg::*;
#(
   parameter int NB_BITS = NB_BITS_DEF,
   parameter int NB_STEP = NB_STEP_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cmd_valid,
   input  logic [1:0]         i_cmd,
   input  logic [NB_STEP-1:0] i_step_count,
   input  logic               i_halt,
   input  logic               i_spi_busy,
   output logic               o_debug_enb,
   output logic [1:0]         o_state,
   output logic [NB_BITS-1:0] o_cycle_count,
   output logic               o_done
);
   state_e state_q, state_d;
   logic [NB_STEP-1:0] rem_q, rem_d;
   logic [NB_BITS-1:0] cnt_q, cnt_d;
   logic done_q, done_d;
   logic enb, is_run, is_step, is_stop, is_clr, fin;
   always_comb begin
      enb     = (state_q == ST_RUN || state_q == ST_STEP) && !i_spi_busy && !i_rst;
      is_run  = i_cmd_valid && i_cmd == CMD_RUN;
      is_step = i_cmd_valid && i_cmd == CMD_STEP;
      is_stop = i_cmd_valid && i_cmd == CMD_STOP;
      is_clr  = i_cmd_valid && i_cmd == CMD_CLEAR;
      fin     = state_q == ST_STEP && enb && rem_q == NB_STEP'(1);
      state_d = state_q;
      rem_d   = (state_q == ST_STEP && enb) ? rem_q - 1'b1 : rem_q;
      cnt_d   = (enb && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
      done_d  = fin;
      case (state_q)
         ST_IDLE: begin
            if (is_run) state_d = ST_RUN;
            else if (is_step && i_step_count != '0) begin
               state_d = ST_STEP;
               rem_d   = i_step_count;
            end else if (is_step) done_d = 1'b1;
         end
         ST_RUN: if (is_stop) state_d = ST_IDLE;
         ST_STEP: begin
            if (is_stop || fin) begin
               state_d = ST_IDLE;
               rem_d   = '0;
            end
         end
         default: ;
      endcase
      // halt outranks stop and completion, but a completing step still reports done
      if (enb && i_halt) state_d = ST_HALTED;
      if (is_clr) begin
         state_d = ST_IDLE;
         rem_d   = '0;
         cnt_d   = '0;
         done_d  = 1'b0;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end
   assign o_debug_enb   = enb;
   assign o_state       = state_q;
   assign o_cycle_count = cnt_q;
   assign o_done        = done_q;
endmodule

// File: tb/tb_debug_step_controller.sv
// tb_debug_step_controller: directed and random checks against a rule-level model
module tb_debug_step_controller;
   logic clk = 1'b0;
   logic rst, cmd_valid, halt, busy;
   logic [1:0] cmd;
   logic [15:0] step_n;
   logic enb32, enb4, done32, done4;
   logic [1:0] st32, st4;
   logic [31:0] cnt32;
   logic [3:0] cnt4;

   debug_step_controller dut (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
      .i_step_count(step_n), .i_halt(halt), .i_spi_busy(busy),
      .o_debug_enb(enb32), .o_state(st32), .o_cycle_count(cnt32), .o_done(done32)
   );
   debug_step_controller #(.NB_BITS(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
      .i_step_count(step_n), .i_halt(halt), .i_spi_busy(busy),
      .o_debug_enb(enb4), .o_state(st4), .o_cycle_count(cnt4), .o_done(done4)
   );

   always #5 clk = ~clk;

   int m_state, m_rem;
   longint m_cnt;
   bit m_done, exp_enb, obs_enb, obs_enb4;
   int n_cmp = 0, n_bad = 0;

   function automatic longint sat4(input longint v);
      return (v > 15) ? 15 : v;
   endfunction

   // apply one cycle of inputs, sample the enable mid-cycle, advance the model at the edge
   task automatic tick(input bit r, input bit v, input int c, input int n, input bit h, input bit b);
      bit clr, fin;
      rst = r; cmd_valid = v; cmd = 2'(c); step_n = 16'(n); halt = h; busy = b;
      #2;
      obs_enb  = enb32;
      obs_enb4 = enb4;
      exp_enb  = !r && (m_state == 1 || m_state == 2) && !b;
      @(posedge clk);
      if (r) begin
         m_state = 0; m_rem = 0; m_cnt = 0; m_done = 0;
      end else if (v && c == 3) begin
         m_state = 0; m_rem = 0; m_cnt = 0; m_done = 0;
      end else begin
         if (exp_enb) m_cnt++;
         fin = m_state == 2 && exp_enb && m_rem == 1;
         if (m_state == 2 && exp_enb) m_rem--;
         m_done = fin;
         if (h && exp_enb) m_state = 3;
         else if (fin) m_state = 0;
         else if (m_state == 0 && v && c == 0) m_state = 1;
         else if (m_state == 0 && v && c == 1) begin
            if (n > 0) begin m_state = 2; m_rem = n; end
            else m_done = 1;
         end else if ((m_state == 1 || m_state == 2) && v && c == 2) m_state = 0;
      end
      #1;
   endtask

   task automatic nop(); tick(0, 0, 0, 0, 0, 0); endtask

   task automatic test_reset();
      m_state = 0; m_rem = 0; m_cnt = 0; m_done = 0;
      tick(1, 1, 0, 0, 0, 0);
      tick(1, 1, 1, 3, 1, 0);
      n_cmp++; if (obs_enb !== 1'b0) begin n_bad++; $display("FAIL reset_enb got %0b want 0", obs_enb); end
      n_cmp++; if (st32 !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", st32); end
      n_cmp++; if (cnt32 !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cnt32); end
      n_cmp++; if (done32 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done32); end
   endtask

   task automatic test_run_stop();
      int hi = 0;
      tick(0, 1, 0, 0, 0, 0);
      n_cmp++; if (obs_enb !== 1'b0) begin n_bad++; $display("FAIL run_cmd_enb got %0b want 0", obs_enb); end
      for (int i = 0; i < 10; i++) begin
         nop();
         hi += obs_enb;
         n_cmp++; if (obs_enb !== exp_enb) begin n_bad++; $display("FAIL run_enb[%0d] got %0b want %0b", i, obs_enb, exp_enb); end
      end
      tick(0, 1, 2, 0, 0, 0);
      hi += obs_enb;
      n_cmp++; if (hi != 11) begin n_bad++; $display("FAIL run_enb_cycles got %0d want 11", hi); end
      n_cmp++; if (cnt32 !== 32'd11) begin n_bad++; $display("FAIL run_count got %0d want 11", cnt32); end
      n_cmp++; if (st32 !== 2'd0) begin n_bad++; $display("FAIL run_stop_state got %0d want 0", st32); end
   endtask

   task automatic test_step_busy();
      int hi = 0, dn = 0;
      tick(0, 1, 3, 0, 0, 0);
      tick(0, 1, 1, 3, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0, 0, 0, i == 1);
         hi += obs_enb;
         dn += done32;
      end
      nop();
      dn += done32;
      n_cmp++; if (hi != 3) begin n_bad++; $display("FAIL step_enb_cycles got %0d want 3", hi); end
      n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL step_done_pulses got %0d want 1", dn); end
      n_cmp++; if (cnt32 !== 32'd3) begin n_bad++; $display("FAIL step_count got %0d want 3", cnt32); end
      n_cmp++; if (st32 !== 2'd0) begin n_bad++; $display("FAIL step_state got %0d want 0", st32); end
   endtask

   task automatic test_step_zero();
      tick(0, 1, 1, 0, 0, 0);
      n_cmp++; if (obs_enb !== 1'b0) begin n_bad++; $display("FAIL step0_enb got %0b want 0", obs_enb); end
      n_cmp++; if (done32 !== 1'b1) begin n_bad++; $display("FAIL step0_done got %0b want 1", done32); end
      n_cmp++; if (st32 !== 2'd0) begin n_bad++; $display("FAIL step0_state got %0d want 0", st32); end
      nop();
      n_cmp++; if (done32 !== 1'b0 || obs_enb !== 1'b0) begin n_bad++; $display("FAIL step0_after got done=%0b enb=%0b want 0/0", done32, obs_enb); end
   endtask

   task automatic test_halt_run();
      tick(0, 1, 3, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) tick(0, 0, 0, 0, i == 5, 0);
      n_cmp++; if (st32 !== 2'd3) begin n_bad++; $display("FAIL halt_state got %0d want 3", st32); end
      n_cmp++; if (cnt32 !== 32'd5) begin n_bad++; $display("FAIL halt_count got %0d want 5", cnt32); end
      tick(0, 1, 0, 0, 0, 0);
      n_cmp++; if (obs_enb !== 1'b0) begin n_bad++; $display("FAIL halted_enb got %0b want 0", obs_enb); end
      n_cmp++; if (st32 !== 2'd3) begin n_bad++; $display("FAIL halted_run_ignored got %0d want 3", st32); end
      tick(0, 1, 3, 0, 0, 0);
      n_cmp++; if (st32 !== 2'd0 || cnt32 !== 32'd0) begin n_bad++; $display("FAIL halt_clear got state=%0d count=%0d want 0/0", st32, cnt32); end
   endtask

   task automatic test_halt_final();
      tick(0, 1, 1, 2, 0, 0);
      nop();
      tick(0, 0, 0, 0, 1, 0);
      n_cmp++; if (done32 !== 1'b1) begin n_bad++; $display("FAIL halt_final_done got %0b want 1", done32); end
      n_cmp++; if (st32 !== 2'd3) begin n_bad++; $display("FAIL halt_final_state got %0d want 3", st32); end
      tick(0, 1, 3, 0, 0, 0);
   endtask

   task automatic test_saturate();
      tick(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) nop();
      n_cmp++; if (cnt4 !== 4'd15) begin n_bad++; $display("FAIL sat4_count got %0d want 15", cnt4); end
      n_cmp++; if (cnt32 !== 32'd20) begin n_bad++; $display("FAIL sat32_count got %0d want 20", cnt32); end
      tick(1, 0, 0, 0, 0, 0);
      n_cmp++; if (obs_enb !== 1'b0 || obs_enb4 !== 1'b0) begin n_bad++; $display("FAIL rst_midrun_enb got %0b/%0b want 0/0", obs_enb, obs_enb4); end
      n_cmp++; if (st32 !== 2'd0 || cnt32 !== 32'd0 || done32 !== 1'b0 || st4 !== 2'd0 || cnt4 !== 4'd0) begin
         n_bad++; $display("FAIL rst_midrun got state=%0d count=%0d done=%0b count4=%0d want zeros", st32, cnt32, done32, cnt4);
      end
   endtask

   task automatic test_random();
      int c, sel;
      for (int i = 0; i < 800; i++) begin
         sel = $urandom_range(0, 9);
         c = (sel < 4) ? 0 : (sel < 7) ? 1 : (sel < 9) ? 2 : 3;
         tick($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, c, $urandom_range(0, 5),
              $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
         n_cmp++; if (obs_enb !== exp_enb || obs_enb4 !== exp_enb) begin n_bad++; $display("FAIL rnd_enb[%0d] got %0b/%0b want %0b", i, obs_enb, obs_enb4, exp_enb); end
         n_cmp++; if (st32 !== 2'(m_state) || st4 !== 2'(m_state)) begin n_bad++; $display("FAIL rnd_state[%0d] got %0d/%0d want %0d", i, st32, st4, m_state); end
         n_cmp++; if (cnt32 !== 32'(m_cnt)) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, cnt32, m_cnt); end
         n_cmp++; if (cnt4 !== 4'(sat4(m_cnt))) begin n_bad++; $display("FAIL rnd_count4[%0d] got %0d want %0d", i, cnt4, sat4(m_cnt)); end
         n_cmp++; if (done32 !== m_done || done4 !== m_done) begin n_bad++; $display("FAIL rnd_done[%0d] got %0b/%0b want %0b", i, done32, done4, m_done); end
      end
   endtask

   initial begin
      test_reset();
      test_run_stop();
      test_step_busy();
      test_step_zero();
      test_halt_run();
      test_halt_final();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
